// File: rtl/accum_host_driver_if.sv
// Signal bundle between the host driver, its stream source/sink and one accumulate kernel.
// master is the driver's view; slave is the environment (stream endpoints plus kernel).
interface accum_host_driver_if #(
  parameter int AW = 10,
  parameter int DW = 64
);
  logic          start;
  logic [AW-1:0] init_i;
  logic [DW-1:0] init_acc;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;
  logic          kernel_result;
  logic          k_r_enable;
  logic [AW-1:0] k_init_i;
  logic [DW-1:0] k_init_acc;
  logic          k_controlArr;
  logic          k_w_enable;
  logic          k_result;
  logic          k_WEnable;
  logic [AW-1:0] k_Addr;
  logic [DW-1:0] k_WData;
  logic [DW-1:0] k_RData;

  modport master (
    input  start, init_i, init_acc, in_valid, in_data, out_ready,
           k_w_enable, k_result, k_RData,
    output in_ready, out_valid, out_data, out_last, busy, done, err, kernel_result,
           k_r_enable, k_init_i, k_init_acc, k_controlArr, k_WEnable, k_Addr, k_WData
  );

  modport slave (
    output start, init_i, init_acc, in_valid, in_data, out_ready,
           k_w_enable, k_result, k_RData,
    input  in_ready, out_valid, out_data, out_last, busy, done, err, kernel_result,
           k_r_enable, k_init_i, k_init_acc, k_controlArr, k_WEnable, k_Addr, k_WData
  );
endinterface

// File: rtl/accum_host_driver.sv
// Host driver: loads the kernel array through the back-door port, kicks the kernel,
// waits for completion (with timeout) and streams the array back through a 2-entry skid FIFO.
module accum_host_driver #(
  parameter int LEN     = 1000,
  parameter int AW      = 10,
  parameter int DW      = 64,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  accum_host_driver_if.master bus
);
  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_READ} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_init_i;
  logic [DW-1:0] r_init_acc;
  logic [AW-1:0] r_wcnt;
  logic [AW-1:0] r_raddr;
  logic [AW-1:0] r_head_idx;
  logic [CW-1:0] r_wait_cnt;
  logic          r_err;
  logic          r_done;
  logic          r_kresult;
  logic          r_issue_done;
  logic          r_inflight;
  logic [DW-1:0] r_fifo [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  logic          w_load_fire;
  logic          w_pop;
  logic          w_last_pop;
  logic          w_issue;
  logic          w_timeout;
  logic [2:0]    w_occ;

  assign w_load_fire = (r_state == S_LOAD) && bus.in_valid;
  assign w_pop       = (r_count != 2'd0) && bus.out_ready;
  assign w_last_pop  = w_pop && (r_head_idx == LAST);
  // Occupancy after this cycle's pop plus the word already in flight; a new read
  // issued now lands two edges later, so this keeps the FIFO from overflowing.
  assign w_occ       = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue     = (r_state == S_READ) && !r_issue_done && (w_occ < 3'd2);
  assign w_timeout   = (r_state == S_WAIT) && !bus.k_w_enable &&
                       (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    bus.in_ready     = 1'b0;
    bus.k_WEnable    = 1'b0;
    bus.k_r_enable   = 1'b0;
    bus.k_controlArr = 1'b1;
    bus.k_Addr       = r_wcnt;
    bus.busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_LOAD;
      S_LOAD: begin
        bus.in_ready  = 1'b1;
        bus.k_WEnable = bus.in_valid;
        if (w_load_fire && (r_wcnt == LAST)) w_state_next = S_KICK;
      end
      S_KICK: begin
        bus.k_controlArr = 1'b0;
        bus.k_r_enable   = 1'b1;
        w_state_next     = S_WAIT;
      end
      S_WAIT: begin
        bus.k_controlArr = 1'b0;
        if (bus.k_w_enable) w_state_next = S_READ;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_READ: begin
        bus.k_Addr = r_raddr;
        if (w_last_pop) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_i     <= '0;
      r_init_acc   <= '0;
      r_wcnt       <= '0;
      r_raddr      <= '0;
      r_head_idx   <= '0;
      r_wait_cnt   <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_kresult    <= 1'b0;
      r_issue_done <= 1'b0;
      r_inflight   <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_init_i     <= bus.init_i;
          r_init_acc   <= bus.init_acc;
          r_err        <= 1'b0;
          r_wcnt       <= '0;
          r_raddr      <= '0;
          r_head_idx   <= '0;
          r_wait_cnt   <= '0;
          r_issue_done <= 1'b0;
        end
        S_LOAD: if (w_load_fire && (r_wcnt != LAST)) r_wcnt <= r_wcnt + 1'b1;
        S_WAIT: begin
          if (bus.k_w_enable) begin
            r_kresult <= bus.k_result;
          end else if (w_timeout) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (r_raddr == LAST) r_issue_done <= 1'b1;
            else                 r_raddr      <= r_raddr + 1'b1;
          end
          if (w_pop && !w_last_pop) r_head_idx <= r_head_idx + 1'b1;
          if (w_last_pop) r_done <= 1'b1;
        end
        default: ;
      endcase
      if (w_last_pop) begin
        r_count  <= 2'd0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
        r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
    end
  end

  // Skid storage holds data only; occupancy is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (r_inflight) r_fifo[r_wr_ptr] <= bus.k_RData;
  end

  assign bus.out_valid     = (r_count != 2'd0);
  assign bus.out_data      = r_fifo[r_rd_ptr];
  assign bus.out_last      = (r_count != 2'd0) && (r_head_idx == LAST);
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.kernel_result = r_kresult;
  assign bus.k_init_i      = r_init_i;
  assign bus.k_init_acc    = r_init_acc;
  assign bus.k_WData       = bus.in_data;
endmodule

// File: tb/tb_accum_host_driver.sv
// Directed bench for accum_host_driver with a behavioural prefix-sum kernel model.
`define CHK(tag, obs, exp) \
  begin \
    n_checks++; \
    assert ((obs) === (exp)) else begin \
      n_errors++; \
      $error("FAIL %s: got %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_accum_host_driver;
  localparam int LEN = 1000;
  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int TO  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accum_host_driver_if #(.AW(AW), .DW(DW)) hif ();

  accum_host_driver #(.LEN(LEN), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Kernel model: back-door port while controlArr=1; on r_enable, after a short delay,
  // a[i] = acc += a[i] for i >= init_i and raise w_enable until the next kick.
  logic [DW-1:0] kmem [LEN];
  logic [DW-1:0] exp_mem [LEN];
  logic          exp_res;
  bit            k_hang = 1'b0;
  logic          krun;
  int            kdelay;

  always @(posedge clk) begin
    logic [DW-1:0] acc;
    if (rst) begin
      krun           <= 1'b0;
      kdelay         <= 0;
      hif.k_w_enable <= 1'b0;
      hif.k_result   <= 1'b0;
    end else begin
      if (hif.k_controlArr) begin
        if (hif.k_WEnable) kmem[hif.k_Addr] <= hif.k_WData;
        hif.k_RData <= kmem[hif.k_Addr];
      end
      if (hif.k_r_enable) begin
        krun           <= !k_hang;
        kdelay         <= 5;
        hif.k_w_enable <= 1'b0;
      end else if (krun) begin
        if (kdelay != 0) begin
          kdelay <= kdelay - 1;
        end else begin
          acc = hif.k_init_acc;
          for (int i = int'(hif.k_init_i); i < LEN; i++) begin
            acc = acc + kmem[i];
            kmem[i] <= acc;
          end
          hif.k_result   <= acc[0];
          hif.k_w_enable <= 1'b1;
          krun           <= 1'b0;
        end
      end
    end
  end

  task automatic compute_expected(input logic [DW-1:0] v, input logic [AW-1:0] ii,
                                  input logic [DW-1:0] a0);
    logic [DW-1:0] acc;
    acc = a0;
    for (int k = 0; k < LEN; k++) begin
      if (k < int'(ii)) exp_mem[k] = v;
      else begin
        acc = acc + v;
        exp_mem[k] = acc;
      end
    end
    exp_res = acc[0];
  endtask

  task automatic start_run(input logic [AW-1:0] ii, input logic [DW-1:0] a0);
    @(negedge clk);
    hif.start    = 1'b1;
    hif.init_i   = ii;
    hif.init_acc = a0;
    @(negedge clk);
    hif.start = 1'b0;
    `CHK("start_busy", hif.busy, 1'b1)
    `CHK("start_err_clear", hif.err, 1'b0)
  endtask

  // Streams LEN copies of v; a stray start with other init values is pulsed mid-load.
  task automatic load_phase(input logic [DW-1:0] v, input bit gap,
                            input logic [AW-1:0] ii, input logic [DW-1:0] a0);
    int c = 0;
    int n = 0;
    while (n < LEN && c < 5000) begin
      hif.in_valid = !(gap && (c % 3 == 2));
      hif.in_data  = v;
      hif.start    = (c == 10);
      if (c == 10) begin
        hif.init_i   = '0;
        hif.init_acc = 64'd123;
      end
      if (hif.in_valid && hif.in_ready) n++;
      c++;
      @(negedge clk);
    end
    hif.in_valid = 1'b0;
    hif.start    = 1'b0;
    `CHK("load_words", n, LEN)
    `CHK("load_cycles", c, (gap ? 1499 : 1000))
    `CHK("kick_in_ready", hif.in_ready, 1'b0)
    `CHK("kick_r_enable", hif.k_r_enable, 1'b1)
    `CHK("kick_controlArr", hif.k_controlArr, 1'b0)
    `CHK("kick_init_i", hif.k_init_i, ii)
    `CHK("kick_init_acc", hif.k_init_acc, a0)
  endtask

  task automatic await_read();
    int w = 0;
    @(negedge clk);
    while (hif.k_controlArr === 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    `CHK("read_entry", hif.k_controlArr, 1'b1)
  endtask

  task automatic readback(input bit stall, input int stop_at);
    int idx = 0, cyc = 0, first = -1, last_cyc = -1;
    int mism = 0, lerr = 0, unst = 0;
    bit pst = 1'b0;
    logic rdy;
    logic [DW-1:0] pd = '0;
    while (idx < stop_at && cyc < 10000) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hif.out_ready = rdy;
      if (pst && (hif.out_valid !== 1'b1 || hif.out_data !== pd)) unst++;
      if (hif.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        if (rdy) begin
          if (hif.out_data !== exp_mem[idx]) mism++;
          if (hif.out_last !== (idx == LEN - 1)) lerr++;
          idx++;
          last_cyc = cyc;
        end
        pst = !rdy;
        pd  = hif.out_data;
      end else begin
        pst = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    hif.out_ready = 1'b0;
    `CHK("read_words", idx, stop_at)
    `CHK("read_first_latency", first, 2)
    `CHK("read_data_mismatches", mism, 0)
    `CHK("read_last_errors", lerr, 0)
    `CHK("read_stall_unstable", unst, 0)
    if (!stall && stop_at == LEN) `CHK("read_cycles", last_cyc, LEN + 1)
  endtask

  task automatic finish_check();
    `CHK("end_done", hif.done, 1'b1)
    `CHK("end_busy", hif.busy, 1'b0)
    `CHK("end_out_valid", hif.out_valid, 1'b0)
    `CHK("end_err", hif.err, 1'b0)
    `CHK("end_kernel_result", hif.kernel_result, exp_res)
    @(negedge clk);
    `CHK("end_done_single", hif.done, 1'b0)
  endtask

  task automatic do_run(input string name, input logic [DW-1:0] v, input logic [AW-1:0] ii,
                        input logic [DW-1:0] a0, input bit gap, input bit stall,
                        input int stop_at);
    int e0 = n_errors;
    compute_expected(v, ii, a0);
    start_run(ii, a0);
    load_phase(v, gap, ii, a0);
    await_read();
    readback(stall, stop_at);
    if (stop_at == LEN) finish_check();
    $display("run %s: v=%0d init_i=%0d init_acc=%0d gap=%0d stall=%0d words=%0d new_errors=%0d",
             name, v, ii, a0, gap, stall, stop_at, n_errors - e0);
  endtask

  initial begin
    int t;
    hif.start     = 1'b0;
    hif.init_i    = '0;
    hif.init_acc  = '0;
    hif.in_valid  = 1'b0;
    hif.in_data   = '0;
    hif.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    `CHK("rst_busy", hif.busy, 1'b0)
    `CHK("rst_in_ready", hif.in_ready, 1'b0)
    `CHK("rst_out_valid", hif.out_valid, 1'b0)
    `CHK("rst_out_last", hif.out_last, 1'b0)
    `CHK("rst_done", hif.done, 1'b0)
    `CHK("rst_err", hif.err, 1'b0)
    `CHK("rst_kernel_result", hif.kernel_result, 1'b0)
    `CHK("rst_k_r_enable", hif.k_r_enable, 1'b0)
    `CHK("rst_k_WEnable", hif.k_WEnable, 1'b0)
    `CHK("rst_k_controlArr", hif.k_controlArr, 1'b1)
    `CHK("rst_k_Addr", hif.k_Addr, 10'd0)

    do_run("ones",    64'd1, 10'd0,   64'd0, 1'b0, 1'b0, LEN);
    do_run("twos",    64'd2, 10'd998, 64'd5, 1'b0, 1'b0, LEN);
    do_run("stalled", 64'd1, 10'd0,   64'd0, 1'b0, 1'b1, LEN);
    do_run("gapped",  64'd1, 10'd0,   64'd0, 1'b1, 1'b0, LEN);

    // Kernel never completes: expect abort TIMEOUT cycles after WAIT entry.
    k_hang = 1'b1;
    start_run(10'd0, 64'd0);
    load_phase(64'd1, 1'b0, 10'd0, 64'd0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (hif.done !== 1'b1 && t < 400);
    `CHK("timeout_cycles", t, TO + 1)
    `CHK("timeout_err", hif.err, 1'b1)
    `CHK("timeout_busy", hif.busy, 1'b0)
    @(negedge clk);
    `CHK("timeout_done_single", hif.done, 1'b0)
    `CHK("timeout_err_sticky", hif.err, 1'b1)
    $display("run timeout: cycles_from_kick=%0d err=%0d", t, hif.err);
    k_hang = 1'b0;

    // Reset mid-READ, then a fresh run.
    do_run("rst_mid_read", 64'd1, 10'd0, 64'd0, 1'b0, 1'b0, 500);
    rst = 1'b1;
    @(negedge clk);
    `CHK("midrst_out_valid", hif.out_valid, 1'b0)
    `CHK("midrst_busy", hif.busy, 1'b0)
    `CHK("midrst_controlArr", hif.k_controlArr, 1'b1)
    `CHK("midrst_in_ready", hif.in_ready, 1'b0)
    rst = 1'b0;
    do_run("after_rst", 64'd2, 10'd998, 64'd5, 1'b0, 1'b0, LEN);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/accum_host_driver.md
Name: accum_host_driver

Overview:
- Host-side initiator for the synthesized accumulate kernel (`main`).
- Streams LEN words into the kernel's array `a` through the controlArr back-door port, then pulses r_enable with init_i/init_acc.
- Waits for w_enable, then streams the whole array back out with valid/ready backpressure.
- Sits between a testbench/DMA stream source/sink and one kernel instance.

Parameters:
- LEN, 1000: array depth; words loaded and read back per run.
- AW, 10: array address width.
- DW, 64: data width.
- TIMEOUT, 65535: max cycles to wait for k_w_enable before aborting with err.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- init_i  in  AW  kernel start index, latched on start
- init_acc  in  DW  kernel initial accumulator, latched on start
- in_valid  in  1  load-stream word valid
- in_ready  out  1  load-stream ready
- in_data  in  DW  load word, signed
- out_valid  out  1  readback word valid
- out_ready  in  1  readback sink ready
- out_data  out  DW  readback word
- out_last  out  1  marks word LEN-1
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the last word is accepted or on abort
- err  out  1  sticky timeout flag; cleared by next start or rst
- kernel_result  out  1  k_result latched when k_w_enable is seen
- k_r_enable  out  1  kernel start
- k_init_i  out  AW  kernel argument
- k_init_acc  out  DW  kernel argument
- k_controlArr  out  1  back-door select
- k_w_enable  in  1  kernel done level
- k_result  in  1  kernel result
- k_WEnable  out  1  back-door write enable
- k_Addr  out  AW  back-door address
- k_WData  out  DW  back-door write data
- k_RData  in  DW  back-door read data; valid one cycle after the address is presented with k_WEnable=0

Behaviour:
- Reset values: state=IDLE; in_ready, out_valid, out_last, done, err, kernel_result, k_r_enable and k_WEnable are 0; k_controlArr=1; address counters 0.
- k_controlArr is 1 in every state except KICK and WAIT, so kernel garbage-state accesses never reach the array.
- IDLE: when start=1, latch init_i and init_acc, clear err, clear the counters, go to LOAD.
- LOAD: in_ready=1. Each in_valid&&in_ready cycle asserts k_WEnable=1 with k_Addr=wcnt and k_WData=in_data, then increments wcnt. After word LEN-1 is accepted, go to KICK. in_ready=0 on the following cycle.
- KICK (exactly 1 cycle): k_controlArr=0, k_r_enable=1, k_init_i and k_init_acc driven from the latches; go to WAIT. k_w_enable is ignored during KICK because it may be stale from the previous run.
- WAIT: k_controlArr=0 and the cycle counter increments.
  - k_w_enable=1: latch kernel_result=k_result, go to READ.
  - Counter reaches TIMEOUT first: set err, pulse done, return to IDLE.
- READ: k_WEnable=0. Issue address raddr to k_Addr only if there is skid room, i.e. (entries + in-flight) < 2.
  - Capture k_RData into the 2-entry skid FIFO the cycle after issue.
  - out_valid = FIFO non-empty; out_data = FIFO head; out_last when head index = LEN-1.
  - Zero bubbles with out_ready held high: one word per cycle after the first, which appears 2 cycles after READ entry.
  - out_valid and out_data must stay stable while out_ready=0.
- After the LEN-1 word handshake: pulse done, go to IDLE.
- start while busy: ignored.
- rst in any state (mid-LOAD, WAIT, READ): return to IDLE next cycle and flush the FIFO. Array contents are undefined and k_controlArr returns to 1.
- Address counters never wrap; they stop at LEN-1.

Test Plan:
- Load a[k]=1 for all k, init_i=0, init_acc=0, out_ready=1 -> readback a[k]=k+1; out_last on word 999; kernel_result=0; done pulses once.
- Load a[k]=2, init_i=998, init_acc=5 -> a[0..997]=2, a[998]=7, a[999]=9.
- Same as the first run but with out_ready toggling 1,0,0,1 pseudo-randomly -> identical data sequence, no duplicates or drops, out_data stable while stalled.
- in_valid gapped every third cycle during LOAD -> LOAD takes ~1500 cycles; final readback matches the first run.
- Kernel model whose k_w_enable never rises, TIMEOUT=100 -> err=1 and done pulse 100 cycles after WAIT entry; busy=0 after.
- rst asserted mid-READ at word 500, then a fresh run -> clean IDLE, out_valid=0 one cycle after rst, second run's readback correct.
